pulse_generator: RTL and testbench

- Inverse companion of the edge-detection utility: converts single-cycle event strobes back into level pulses of fixed width.
- Each accepted strobe produces exactly one high window of HIGH_CYCLES clocks, followed by at least GAP_CYCLES low clocks.
- Strobes arriving while a pulse is in progress are counted and replayed in order.
- Sits in util/ and drives LEDs, handshake request lines and debug outputs from edge-detector strobes.

---
 rtl/util_pkg.sv | 18 +
 rtl/pulse_generator.sv | 123 ++++++++++++
 tb/tb_pulse_generator.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/util_pkg.sv
// Shared types and helpers for the util/ pulse_generator block.
// Contents: pulse_state_e (2-bit FSM encoding) and cnt_width(), which sizes
// the pulse/gap down-counter so it can hold max(HIGH_CYCLES, GAP_CYCLES).
package util_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pulse_state_e;

  function automatic int cnt_width(input int high_cycles, input int gap_cycles);
    int m;
    m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_generator.sv
// pulse_generator: turns single-cycle strobes into fixed-width level pulses
// separated by a minimum low gap; strobes seen mid-pulse are queued
// (saturating counter) and replayed back-to-back.
// Ports: clk, rst_n (async active-low), trig_in (strobe), clr_ovf (clears ovf);
//        out (pulse), busy (not idle), pend (queued strobes), ovf (sticky drop).
// Option: define PULSE_GEN_RETRIGGER_EN to let a strobe during the high window
//         extend the pulse instead of queueing.
module pulse_generator
  import util_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig_in,
  input  logic              clr_ovf,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  localparam int CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  pulse_state_e  state;
  logic [CW-1:0] cnt;

  logic cnt_zero;
  logic gap_done;
  logic replay;
  logic start_direct;
  logic retrig_hit;
  logic enqueue;
  logic drop;

`ifdef PULSE_GEN_RETRIGGER_EN
  assign retrig_hit = (state == HIGH) && trig_in;
`else
  assign retrig_hit = 1'b0;
`endif

  always_comb begin
    cnt_zero     = (cnt == '0);
    gap_done     = (state == GAP) && cnt_zero;
    // Queued strobes take priority over a fresh one on the last gap clock.
    replay       = gap_done && (pend != '0);
    start_direct = trig_in && ((state == IDLE) || (gap_done && (pend == '0)));
    enqueue      = trig_in && !start_direct && !retrig_hit;
    // A replay frees a slot in the same clock, so it can never overflow.
    drop         = enqueue && (pend == PEND_MAX) && !replay;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig_in) begin
            state <= HIGH;
            cnt   <= HIGH_LOAD;
            out   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        HIGH: begin
          if (retrig_hit) begin
            cnt <= HIGH_LOAD;
          end else if (cnt_zero) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
            out   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (!cnt_zero) begin
            cnt <= cnt - 1'b1;
          end else if (replay || trig_in) begin
            state <= HIGH;
            cnt   <= HIGH_LOAD;
            out   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          out   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      // Saturating queue: replay and enqueue in one clock cancel out.
      if (replay && !(enqueue && !drop)) begin
        pend <= pend - 1'b1;
      end else if (!replay && enqueue && !drop) begin
        pend <= pend + 1'b1;
      end

      // Set beats clear.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator (HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2).
// A timeline model (pulse start/end edge numbers plus a pending count) is
// compared against the DUT on every falling edge; directed literals pin it.
module tb_pulse_generator;

  localparam int H    = 4;
  localparam int G    = 2;
  localparam int PW   = 2;
  localparam int PMAX = 3;
`ifdef PULSE_GEN_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig_in = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          out;
  logic          busy;
  logic [PW-1:0] pend;
  logic          ovf;

  pulse_generator #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .clr_ovf(clr_ovf),
    .out(out), .busy(busy), .pend(pend), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: edge counter since reset release, current pulse [cs..ce] in edge
  // numbers, number of strobes waiting, sticky overflow.
  int cyc;
  bit act;
  int cs, ce;
  int pm;
  bit om;

  always @(posedge clk or negedge rst_n) begin : model
    int t;
    if (!rst_n) begin
      cyc = 0; act = 1'b0; cs = 0; ce = 0; pm = 0; om = 1'b0;
    end else begin
      bit dropped;
      t = cyc + 1;
      cyc = t;
      dropped = 1'b0;
      if (!act || t >= ce + 1 + G) begin
        // Previous pulse plus its gap is over: a new pulse may start now.
        if (pm > 0) begin
          act = 1'b1; cs = t; ce = t + H - 1; pm = pm - 1;
          if (trig_in) pm = pm + 1;
        end else if (trig_in) begin
          act = 1'b1; cs = t; ce = t + H - 1;
        end else begin
          act = 1'b0;
        end
      end else if (trig_in) begin
        if (RETRIG && t <= ce + 1) ce = t + H - 1;
        else if (pm == PMAX) dropped = 1'b1;
        else pm = pm + 1;
      end
      if (dropped) om = 1'b1;
      else if (clr_ovf) om = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, want %0d", name, cyc, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out", 32'(out), 32'(act && cyc >= cs && cyc <= ce));
      check("busy", 32'(busy), 32'(act && cyc <= ce + G));
      check("pend", 32'(pend), 32'(pm));
      check("ovf", 32'(ovf), 32'(om));
    end
  end

  logic [63:0] trig_v;
  logic [63:0] clr_v;

  // Hand-computed expectations, observed just after edge t.
  task automatic lit(input int ph, input int t);
    case (ph)
      1: case (t)
           9:  check("p1_out_before", 32'(out), 0);
           10: check("p1_out_rise", 32'(out), 1);
           12: check("p1_pend", 32'(pend), 0);
           13: check("p1_out_last", 32'(out), 1);
           14: check("p1_out_fall", 32'(out), 0);
           15: check("p1_busy_gap", 32'(busy), 1);
           16: check("p1_busy_idle", 32'(busy), 0);
           default: ;
         endcase
      2: case (t)
           12: check("p2_pend1", 32'(pend), 1);
           13: check("p2_pend2", 32'(pend), 2);
           16: begin check("p2_pend_replay", 32'(pend), 1); check("p2_out2", 32'(out), 1); end
           22: begin check("p2_pend0", 32'(pend), 0); check("p2_out3", 32'(out), 1); end
           26: check("p2_out3_end", 32'(out), 0);
           default: ;
         endcase
      3: case (t)
           14: begin check("p3_pend_sat", 32'(pend), 3); check("p3_ovf_set", 32'(ovf), 1); end
           19: check("p3_ovf_sticky", 32'(ovf), 1);
           20: check("p3_ovf_clr", 32'(ovf), 0);
           24: check("p3_pend_sat2", 32'(pend), 3);
           25: begin check("p3_set_wins", 32'(ovf), 1); check("p3_pend_hold", 32'(pend), 3); end
           default: ;
         endcase
      4: case (t)
           15: check("p4_pend_gap", 32'(pend), 1);
           16: begin check("p4_pend_keep", 32'(pend), 1); check("p4_out_next", 32'(out), 1); end
           22: begin check("p4_out_third", 32'(out), 1); check("p4_pend_done", 32'(pend), 0); end
           default: ;
         endcase
      5: case (t)
           12: begin check("p5_pend_pre", 32'(pend), 2); check("p5_out_pre", 32'(out), 1); end
           default: ;
         endcase
      6: case (t)
           4: check("p6_out_idle", 32'(out), 0);
           5: begin check("p6_out_latency", 32'(out), 1); check("p6_busy", 32'(busy), 1); end
           default: ;
         endcase
      7: begin
           if (RETRIG) begin
             case (t)
               13: check("p7_pend_retrig", 32'(pend), 0);
               16: check("p7_out_ext", 32'(out), 1);
               17: check("p7_out_ext_end", 32'(out), 0);
               18: check("p7_busy_gap", 32'(busy), 1);
               19: check("p7_busy_idle", 32'(busy), 0);
               default: ;
             endcase
           end else begin
             case (t)
               13: check("p7_pend_queue", 32'(pend), 1);
               14: check("p7_out_fall", 32'(out), 0);
               16: begin check("p7_out_second", 32'(out), 1); check("p7_pend_drain", 32'(pend), 0); end
               default: ;
             endcase
           end
         end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    chk_en  = 1'b0;
    rst_n   = 1'b0;
    trig_in = 1'b0;
    clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic run(input int n, input int ph);
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      lit(ph, t - 1);
      trig_in = trig_v[t];
      clr_ovf = clr_v[t];
    end
    @(negedge clk);
    lit(ph, n);
    trig_in = 1'b0;
    clr_ovf = 1'b0;
  endtask

  initial begin
    // Single strobe.
    do_reset();
    trig_v = '0; clr_v = '0; trig_v[10] = 1'b1;
    run(30, 1);

    // Two strobes queued during the first pulse.
    do_reset();
    trig_v = '0; clr_v = '0;
    trig_v[10] = 1'b1; trig_v[12] = 1'b1; trig_v[13] = 1'b1;
    run(40, 2);

    // Saturation, overflow, clear, and set-beats-clear.
    do_reset();
    trig_v = '0; clr_v = '0;
    for (int i = 10; i <= 14; i++) trig_v[i] = 1'b1;
    clr_v[20] = 1'b1;
    trig_v[23] = 1'b1; trig_v[24] = 1'b1; trig_v[25] = 1'b1; clr_v[25] = 1'b1;
    run(60, 3);

    // Strobe on the last gap clock while one strobe is queued.
    do_reset();
    trig_v = '0; clr_v = '0;
    trig_v[10] = 1'b1; trig_v[12] = 1'b1; trig_v[16] = 1'b1;
    run(40, 4);

    // Asynchronous reset mid-pulse with two strobes queued.
    do_reset();
    trig_v = '0; clr_v = '0;
    trig_v[10] = 1'b1; trig_v[11] = 1'b1; trig_v[12] = 1'b1;
    run(12, 5);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_pend", 32'(pend), 0);
    check("arst_ovf", 32'(ovf), 0);
    do_reset();
    trig_v = '0; clr_v = '0; trig_v[5] = 1'b1;
    run(15, 6);

    // Strobe during the high window: extension or queueing.
    do_reset();
    trig_v = '0; clr_v = '0;
    trig_v[10] = 1'b1; trig_v[13] = 1'b1;
    run(30, 7);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
